// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one dALU between NREQ requesters.
// Each transaction walks IDLE -> ISSUE -> CAPTURE -> RESP. alu_op is non-zero
// only in ISSUE, because the dALU re-executes on every edge while op is valid.
// The arbiter keeps C/Z/O shadow flags per requester, so one requester never
// sees flags left behind by another requester.
// Optional build macro ALU_DIV0_TRAP_EN: a divide by zero is answered at once
// with resp_err=1 and is never issued to the dALU. If the macro is undefined,
// divides are always issued and resp_err stays 0.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_op,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          resp_acc,
  output logic [15:0]          resp_hi,
  output logic                 resp_c,
  output logic                 resp_z,
  output logic                 resp_o,
  output logic                 resp_err,
  output logic [15:0]          alu_a,
  output logic [15:0]          alu_b,
  output logic [7:0]           alu_op,
  output logic                 alu_cf,
  input  logic [15:0]          alu_acc,
  input  logic [15:0]          alu_c,
  input  logic                 alu_cflag,
  input  logic                 alu_zflag,
  input  logic                 alu_oflag
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  localparam logic [7:0] OP_MUL6 = 8'h06;
  localparam logic [7:0] OP_DIV8 = 8'h07;
  localparam logic [7:0] OP_DIV6 = 8'h08;
  localparam logic [7:0] OP_CMP  = 8'h09;
  localparam logic [7:0] OP_TEST = 8'h11;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d, gnt_q, gnt_d;
  logic [7:0]        op_q, op_d;
  logic [15:0]       a_q, a_d, b_q, b_d;
  logic [NREQ-1:0]   sc_q, sc_d, sz_q, sz_d, so_q, so_d;
  logic [IDW-1:0]    resp_id_q, resp_id_d;
  logic [15:0]       resp_acc_q, resp_acc_d, resp_hi_q, resp_hi_d;
  logic              resp_c_q, resp_c_d, resp_z_q, resp_z_d, resp_o_q, resp_o_d;
  logic              resp_err_q, resp_err_d;

  logic              gnt_found;
  logic [IDW-1:0]    gnt_idx;
  int                idx;
  logic [7:0]        g_op;
  logic [15:0]       g_a, g_b;
  logic              div0;
  logic              cls_all, cls_z, cls_acc;
  logic              new_c, new_z, new_o;

  // Round-robin search: first valid requester after the pointer, with wrap.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[IDW-1:0];
      end
    end
  end

  assign g_op = req_op[8*int'(gnt_idx) +: 8];
  assign g_a  = req_a[16*int'(gnt_idx) +: 16];
  assign g_b  = req_b[16*int'(gnt_idx) +: 16];

`ifdef ALU_DIV0_TRAP_EN
  assign div0 = ((g_op == OP_DIV8) && (g_b[7:0] == 8'h00)) ||
                ((g_op == OP_DIV6) && (g_b == 16'h0000));
`else
  assign div0 = 1'b0;
`endif

  // Decode the opcode class of the captured op.
  // Full flags: ADD, ADC, SUB, SUC and CMP. Z only: MUL, DIV and TEST.
  // Result word: every defined op except CMP and TEST.
  always_comb begin
    cls_all = ((op_q >= 8'h01) && (op_q <= 8'h04)) || (op_q == OP_CMP);
    cls_z   = ((op_q >= 8'h05) && (op_q <= 8'h08)) || (op_q == OP_TEST);
    cls_acc = ((op_q >= 8'h01) && (op_q <= 8'h08)) ||
              ((op_q >= 8'h0A) && (op_q <= 8'h10));
    new_c   = cls_all ? alu_cflag : sc_q[gnt_q];
    new_z   = (cls_all || cls_z) ? alu_zflag : sz_q[gnt_q];
    new_o   = cls_all ? alu_oflag : so_q[gnt_q];
  end

  // Next-state logic, the handshake and the dALU drive for each FSM phase.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sc_d       = sc_q;
    sz_d       = sz_q;
    so_d       = so_q;
    resp_id_d  = resp_id_q;
    resp_acc_d = resp_acc_q;
    resp_hi_d  = resp_hi_q;
    resp_c_d   = resp_c_q;
    resp_z_d   = resp_z_q;
    resp_o_d   = resp_o_q;
    resp_err_d = resp_err_q;
    req_ready  = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = '0;
    alu_cf     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found && rst_n) begin
          req_ready[gnt_idx] = 1'b1;
          gnt_d = gnt_idx;
          ptr_d = gnt_idx;
          op_d  = g_op;
          a_d   = g_a;
          b_d   = g_b;
          if (div0) begin
            state_d    = S_RESP;
            resp_id_d  = gnt_idx;
            resp_acc_d = 16'hFFFF;
            resp_hi_d  = 16'hFFFF;
            resp_c_d   = sc_q[gnt_idx];
            resp_z_d   = sz_q[gnt_idx];
            resp_o_d   = so_q[gnt_idx];
            resp_err_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_op  = op_q;
        alu_cf  = sc_q[gnt_q];
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        sc_d[gnt_q] = new_c;
        sz_d[gnt_q] = new_z;
        so_d[gnt_q] = new_o;
        resp_id_d   = gnt_q;
        resp_acc_d  = cls_acc ? alu_acc : 16'h0000;
        resp_hi_d   = ((op_q == OP_MUL6) || (op_q == OP_DIV6)) ? alu_c : 16'h0000;
        resp_c_d    = new_c;
        resp_z_d    = new_z;
        resp_o_d    = new_o;
        resp_err_d  = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State, pointer, latched request, shadow flags and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      gnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sc_q       <= '0;
      sz_q       <= '0;
      so_q       <= '0;
      resp_id_q  <= '0;
      resp_acc_q <= '0;
      resp_hi_q  <= '0;
      resp_c_q   <= 1'b0;
      resp_z_q   <= 1'b0;
      resp_o_q   <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sc_q       <= sc_d;
      sz_q       <= sz_d;
      so_q       <= so_d;
      resp_id_q  <= resp_id_d;
      resp_acc_q <= resp_acc_d;
      resp_hi_q  <= resp_hi_d;
      resp_c_q   <= resp_c_d;
      resp_z_q   <= resp_z_d;
      resp_o_q   <= resp_o_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = resp_id_q;
  assign resp_acc   = resp_acc_q;
  assign resp_hi    = resp_hi_q;
  assign resp_c     = resp_c_q;
  assign resp_z     = resp_z_q;
  assign resp_o     = resp_o_q;
  assign resp_err   = resp_err_q;

endmodule
